// File: rtl/vt512_img_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vt512_img_pkg
// Description : Shared widths, coordinate type, reader FSM states and the
//               stream beat record for the 512x512 single-channel image path.
// Revision    : 1.0 - initial release
// ============================================================================
package vt512_img_pkg;

    localparam int DATA_WIDTH          = 8;
    localparam int MAX_IMAGE_SIZE      = 512;
    localparam int MAX_IMAGE_SIZE_LOG2 = 9;

    // One extra bit so the zero border ring (0 and MAX+1) is addressable.
    localparam int c_COORD_W    = MAX_IMAGE_SIZE_LOG2 + 1;
    localparam int c_FIFO_DEPTH = 4;
    localparam int c_FIFO_PTR_W = $clog2(c_FIFO_DEPTH);
    localparam int c_FIFO_CNT_W = c_FIFO_PTR_W + 1;

    typedef logic [c_COORD_W-1:0]  coord_t;
    typedef logic [DATA_WIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        pixel_t data;
        coord_t x;
        coord_t y;
        logic   eol;
        logic   eof;
    } beat_t;

endpackage
`default_nettype wire

// File: rtl/image_raster_reader_if.sv
`default_nettype none
// ============================================================================
// Interface   : image_raster_reader_if
// Description : Memory read port plus the outgoing pixel stream of the
//               raster reader. master = reader, slave = memory/sink side.
// Revision    : 1.0 - initial release
// ============================================================================
interface image_raster_reader_if;
    import vt512_img_pkg::*;

    logic   mem_we;
    coord_t mem_cell_x;
    coord_t mem_cell_y;
    pixel_t mem_data;

    logic   out_valid;
    logic   out_ready;
    pixel_t out_data;
    coord_t out_x;
    coord_t out_y;
    logic   out_eol;
    logic   out_eof;

    modport master (
        output mem_we, mem_cell_x, mem_cell_y,
        input  mem_data,
        output out_valid, out_data, out_x, out_y, out_eol, out_eof,
        input  out_ready
    );

    modport slave (
        input  mem_we, mem_cell_x, mem_cell_y,
        output mem_data,
        input  out_valid, out_data, out_x, out_y, out_eol, out_eof,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/image_raster_reader_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo
// Description : Small synchronous beat FIFO with occupancy output. The head
//               entry is presented combinationally and stays put until popped.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo
    import vt512_img_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  beat_t                   i_beat,
    input  logic                    i_pop,
    output logic                    o_valid,
    output beat_t                   o_beat,
    output logic [c_FIFO_CNT_W-1:0] o_count
);

    localparam logic [c_FIFO_CNT_W-1:0] c_FULL = c_FIFO_CNT_W'(c_FIFO_DEPTH);

    beat_t                   r_mem [c_FIFO_DEPTH];
    logic [c_FIFO_PTR_W-1:0] r_wr_ptr;
    logic [c_FIFO_PTR_W-1:0] r_rd_ptr;
    logic [c_FIFO_CNT_W-1:0] r_count;
    logic                    w_wr_en;
    logic                    w_rd_en;

    assign w_rd_en = i_pop && (r_count != '0);
    assign w_wr_en = i_push && ((r_count != c_FULL) || w_rd_en);

    assign o_valid = (r_count != '0);
    assign o_beat  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage; cleared on reset so an idle head reads back as all zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_beat;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_FIFO_PTR_W'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + c_FIFO_PTR_W'(1);
            if (w_wr_en && !w_rd_en)      r_count <= r_count + c_FIFO_CNT_W'(1);
            else if (!w_wr_en && w_rd_en) r_count <= r_count - c_FIFO_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/image_raster_reader.sv
`default_nettype none
// ============================================================================
// Module      : image_raster_reader
// Description : Walks the padded pixel memory in raster order, hides the
//               one-cycle read latency and streams pixels with coordinates
//               and end-of-row/end-of-frame markers under credit control.
// Revision    : 1.0 - initial release
// ============================================================================
module image_raster_reader
    import vt512_img_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  coord_t                img_width,
    input  coord_t                img_height,
    input  logic                  pad_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    image_raster_reader_if.master bus
);

    localparam coord_t                c_MAX_DIM = coord_t'(MAX_IMAGE_SIZE);
    localparam coord_t                c_ONE     = coord_t'(1);
    localparam logic [c_FIFO_CNT_W:0] c_CREDITS = (c_FIFO_CNT_W+1)'(c_FIFO_DEPTH);

    state_t r_state, w_state_nxt;

    // Stage 0: the address currently on the memory port (r_x/r_y) and its tag.
    coord_t r_x, r_y;
    coord_t r_x_lo, r_x_hi, r_y_hi;
    logic   r_s0_vld, r_s0_eol, r_s0_eof;
    // Stage 1: tag aligned with mem_data.
    logic   r_s1_vld, r_s1_eol, r_s1_eof;
    coord_t r_s1_x, r_s1_y;
    logic   r_done, r_err;

    logic   w_start_ok, w_launch, w_advance, w_issue, w_frame_done;
    logic   w_at_eol, w_at_last, w_credit_ok, w_pop, w_fifo_valid;
    coord_t w_lo, w_cmd_x_hi, w_cmd_y_hi;
    coord_t w_nx, w_ny, w_nx_hi, w_ny_hi;
    logic [c_FIFO_CNT_W-1:0] w_fifo_count;
    logic [c_FIFO_CNT_W:0]   w_in_use;
    beat_t  w_push_beat, w_head;

    assign w_start_ok = (img_width  != '0) && (img_width  <= c_MAX_DIM) &&
                        (img_height != '0) && (img_height <= c_MAX_DIM);
    assign w_lo       = pad_en ? '0 : c_ONE;
    assign w_cmd_x_hi = pad_en ? img_width  + c_ONE : img_width;
    assign w_cmd_y_hi = pad_en ? img_height + c_ONE : img_height;

    assign w_at_eol   = (r_x == r_x_hi);
    assign w_at_last  = w_at_eol && (r_y == r_y_hi);

    // Every read in flight already owns a FIFO slot, so returned data never drops.
    assign w_in_use    = {1'b0, w_fifo_count} + {{c_FIFO_CNT_W{1'b0}}, r_s0_vld}
                                              + {{c_FIFO_CNT_W{1'b0}}, r_s1_vld};
    assign w_credit_ok = (w_in_use < c_CREDITS);
    assign w_pop       = w_fifo_valid && bus.out_ready;
    assign w_issue     = w_launch || w_advance;

    // Next-state and control decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_launch     = 1'b0;
        w_advance    = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && w_start_ok) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_at_last)        w_state_nxt = ST_DRAIN;
                else if (w_credit_ok) w_advance   = 1'b1;
            end
            ST_DRAIN: begin
                if (w_pop && w_head.eof) begin
                    w_frame_done = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next raster address: first cell of the frame on launch, else step x then y.
    always_comb begin
        w_nx    = r_x;
        w_ny    = r_y;
        w_nx_hi = r_x_hi;
        w_ny_hi = r_y_hi;
        if (w_launch) begin
            w_nx    = w_lo;
            w_ny    = w_lo;
            w_nx_hi = w_cmd_x_hi;
            w_ny_hi = w_cmd_y_hi;
        end else if (w_at_eol) begin
            w_nx = r_x_lo;
            w_ny = r_y + c_ONE;
        end else begin
            w_nx = r_x + c_ONE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Address generator and the two-stage tag pipeline matching read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_x_lo   <= '0;
            r_x_hi   <= '0;
            r_y_hi   <= '0;
            r_s0_vld <= 1'b0;
            r_s0_eol <= 1'b0;
            r_s0_eof <= 1'b0;
            r_s1_vld <= 1'b0;
            r_s1_x   <= '0;
            r_s1_y   <= '0;
            r_s1_eol <= 1'b0;
            r_s1_eof <= 1'b0;
        end else begin
            if (w_launch) begin
                r_x_lo <= w_lo;
                r_x_hi <= w_cmd_x_hi;
                r_y_hi <= w_cmd_y_hi;
            end
            if (w_issue) begin
                r_x      <= w_nx;
                r_y      <= w_ny;
                r_s0_eol <= (w_nx == w_nx_hi);
                r_s0_eof <= (w_nx == w_nx_hi) && (w_ny == w_ny_hi);
            end
            r_s0_vld <= w_issue;
            r_s1_vld <= r_s0_vld;
            r_s1_x   <= r_x;
            r_s1_y   <= r_y;
            r_s1_eol <= r_s0_eol;
            r_s1_eof <= r_s0_eof;
        end
    end

    // One-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_frame_done;
            r_err  <= (r_state == ST_IDLE) && start && !w_start_ok;
        end
    end

    assign w_push_beat = {bus.mem_data, r_s1_x, r_s1_y, r_s1_eol, r_s1_eof};

    stream_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_s1_vld),
        .i_beat  (w_push_beat),
        .i_pop   (w_pop),
        .o_valid (w_fifo_valid),
        .o_beat  (w_head),
        .o_count (w_fifo_count)
    );

    assign bus.mem_we     = 1'b0;
    assign bus.mem_cell_x = r_x;
    assign bus.mem_cell_y = r_y;
    assign bus.out_valid  = w_fifo_valid;
    assign bus.out_data   = w_head.data;
    assign bus.out_x      = w_head.x;
    assign bus.out_y      = w_head.y;
    assign bus.out_eol    = w_head.eol;
    assign bus.out_eof    = w_head.eof;

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_image_raster_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_raster_reader
// Description : Self-checking bench for image_raster_reader with a registered
//               memory model and an expected-beat queue built from raster rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_raster_reader;
    import vt512_img_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   start = 1'b0;
    logic   pad_en = 1'b0;
    coord_t img_width = '0;
    coord_t img_height = '0;
    logic   busy, done, err;

    image_raster_reader_if u_if ();

    image_raster_reader u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .img_width  (img_width),
        .img_height (img_height),
        .pad_en     (pad_en),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bus        (u_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory image: interior cell (x,y) holds 16*y+x, the border ring is zero.
    int cur_w = 4;
    int cur_h = 3;

    function automatic pixel_t pix(input int x, input int y);
        if (x < 1 || y < 1 || x > cur_w || y > cur_h) return '0;
        return pixel_t'(16 * y + x);
    endfunction

    always @(posedge clk) u_if.mem_data <= pix(int'(u_if.mem_cell_x), int'(u_if.mem_cell_y));

    // Sink readiness: mode 0 always ready, mode 1 ready about 30% of cycles.
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        u_if.out_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
    end

    beat_t exp_q[$];

    task automatic build_model(input int w, input int h, input bit pad);
        int lo;
        int xh;
        int yh;
        beat_t b;
        lo = pad ? 0 : 1;
        xh = pad ? w + 1 : w;
        yh = pad ? h + 1 : h;
        exp_q.delete();
        for (int y = lo; y <= yh; y++) begin
            for (int x = lo; x <= xh; x++) begin
                b.data = pix(x, y);
                b.x    = coord_t'(x);
                b.y    = coord_t'(y);
                b.eol  = (x == xh);
                b.eof  = (x == xh) && (y == yh);
                exp_q.push_back(b);
            end
        end
    endtask

    // Stream monitor: every presented beat must equal the model head, held or not.
    int    cyc = 0;
    int    beats = 0;
    int    first_cyc = 0;
    int    last_cyc = 0;
    bit    pend_done = 1'b0;
    beat_t mon_b;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            pend_done = 1'b0;
        end else begin
            check("done_pulse", done, pend_done);
            pend_done = 1'b0;
            if (exp_q.size() == 0) begin
                check("no_beat_expected", u_if.out_valid, 1'b0);
            end else if (u_if.out_valid) begin
                check("beat", {u_if.out_data, u_if.out_x, u_if.out_y, u_if.out_eol, u_if.out_eof},
                      exp_q[0]);
                if (u_if.out_ready) begin
                    mon_b = exp_q.pop_front();
                    if (beats == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    beats++;
                    pend_done = mon_b.eof;
                end
            end
        end
    end

    task automatic issue_start(input int w, input int h, input bit pad);
        img_width  = coord_t'(w);
        img_height = coord_t'(h);
        pad_en     = pad;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1'b1);
        check("busy_low_at_done", busy, 1'b0);
    endtask

    task automatic run_frame(input int w, input int h, input bit pad, input int mode,
                             input bit chk_lat, input string name);
        int n;
        int lo;
        cur_w = w;
        cur_h = h;
        build_model(w, h, pad);
        n = exp_q.size();
        rdy_mode = mode;
        beats = 0;
        issue_start(w, h, pad);
        if (chk_lat) begin
            lo = pad ? 0 : 1;
            @(negedge clk);
            check({name, "_busy_after_e0"}, busy, 1'b1);
            check({name, "_first_addr"}, {u_if.mem_cell_x, u_if.mem_cell_y},
                  {coord_t'(lo), coord_t'(lo)});
            check({name, "_valid_after_e0"}, u_if.out_valid, 1'b0);
            @(negedge clk);
            check({name, "_valid_after_e1"}, u_if.out_valid, 1'b0);
            @(negedge clk);
            check({name, "_valid_after_e2"}, u_if.out_valid, 1'b1);
        end
        wait_done(4000);
        check({name, "_beat_count"}, beats, n);
        check({name, "_model_drained"}, exp_q.size(), 0);
        if (mode == 0) check({name, "_no_bubbles"}, last_cyc - first_cyc, n - 1);
        @(posedge clk);
        #1;
    endtask

    task automatic bad_start(input int w, input int h, input string name);
        issue_start(w, h, 1'b0);
        @(negedge clk);
        check({name, "_err"}, err, 1'b1);
        check({name, "_busy"}, busy, 1'b0);
        @(negedge clk);
        check({name, "_err_single"}, err, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w;
        int h;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {busy, done, err, u_if.out_valid, u_if.out_eol, u_if.out_eof, u_if.mem_we}, '0);
        check("rst_out_data", u_if.out_data, '0);
        check("rst_out_xy", {u_if.out_x, u_if.out_y}, '0);
        check("rst_mem_addr", {u_if.mem_cell_x, u_if.mem_cell_y}, '0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_frame(4, 3, 1'b0, 0, 1'b1, "f4x3");
        run_frame(4, 3, 1'b1, 0, 1'b1, "f4x3_pad");
        run_frame(4, 3, 1'b0, 1, 1'b0, "f4x3_stall");

        bad_start(0, 3, "w0");
        bad_start(4, MAX_IMAGE_SIZE + 1, "h513");

        // A start while busy must be ignored and leave the frame intact.
        cur_w = 4;
        cur_h = 3;
        build_model(4, 3, 1'b0);
        rdy_mode = 1;
        beats = 0;
        issue_start(4, 3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        issue_start(2, 2, 1'b1);
        @(negedge clk);
        check("busy_start_err", err, 1'b0);
        check("busy_start_busy", busy, 1'b1);
        wait_done(4000);
        check("busy_start_beats", beats, 12);
        check("busy_start_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;

        run_frame(1, 1, 1'b0, 0, 1'b1, "f1x1");

        for (int i = 0; i < 6; i++) begin
            w = $urandom_range(1, 8);
            h = $urandom_range(1, 6);
            run_frame(w, h, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'b0, "rand");
        end

        // Reset in the middle of a frame, then replay it from the top.
        cur_w = 4;
        cur_h = 3;
        build_model(4, 3, 1'b0);
        rdy_mode = 0;
        beats = 0;
        issue_start(4, 3, 1'b0);
        n = 0;
        while (beats < 5 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("midrst_reached_5", beats, 5);
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {busy, done, err, u_if.out_valid, u_if.out_eol, u_if.out_eof, u_if.mem_we}, '0);
        check("midrst_out", {u_if.out_data, u_if.out_x, u_if.out_y}, '0);
        check("midrst_mem_addr", {u_if.mem_cell_x, u_if.mem_cell_y}, '0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(4, 3, 1'b0, 0, 1'b1, "replay");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/image_raster_reader.md
# image_raster_reader

Streams an image out of the padded single-channel pixel memory in raster order. Given a start command and image dimensions, the block drives the memory's cell_x/cell_y read port, absorbs the memory's one-cycle registered read latency, and presents pixels on a valid/ready stream with coordinates and end-of-row/end-of-frame markers. It is the read-side counterpart to the pixel writers. It sits between the per-channel memory and downstream filter/output engines.

## Interface
- DATA_WIDTH, 8, pixel width
- MAX_IMAGE_SIZE, 512, maximum interior width/height
- MAX_IMAGE_SIZE_LOG2, 9, coordinate ports are MAX_IMAGE_SIZE_LOG2+1 bits wide (0..MAX_IMAGE_SIZE+1)
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle command, sampled only in IDLE
- img_width, img_height  in  LOG2+1  interior dimensions, sampled with start
- pad_en  in  1  sampled with start; 1 = include the zero border ring
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse when the last beat is accepted
- err  out  1  one-cycle pulse when a start is rejected
- mem_we  out  1  tied 0
- mem_cell_x, mem_cell_y  out  LOG2+1  registered read address
- mem_data  in  DATA_WIDTH  memory read data, valid one cycle after the address is sampled
- out_valid, out_ready  out/in  1  stream handshake
- out_data  out  DATA_WIDTH  pixel
- out_x, out_y  out  LOG2+1  memory coordinates of the pixel
- out_eol  out  1  last pixel of the row
- out_eof  out  1  last pixel of the frame

## Operation
- Scan range: x,y run from 1..W and 1..H. With pad_en they run from 0..W+1 and 0..H+1. x is the inner loop and y is the outer loop. The read address is mem_cell_x = x, mem_cell_y = y.
- FSM IDLE -> RUN -> DRAIN -> IDLE.
  - IDLE: a start with 1 ≤ W,H ≤ MAX_IMAGE_SIZE latches the parameters and enters RUN. Any other start pulses err and stays in IDLE.
  - RUN: a read is issued each cycle that credits allow. After the last address is issued, the FSM moves to DRAIN.
  - DRAIN: holds until the buffer is empty and the final beat is accepted. It then pulses done and returns to IDLE.
- Credits: a 4-entry output FIFO. A read is issued only when (FIFO occupancy + reads in flight) < 4. No returned pixel is ever dropped.
- Coordinates and eol/eof travel alongside each read through a 2-stage tag pipeline matched to the data latency.
- start is ignored while busy, and err does not pulse in that case.
- Stream rule: once out_valid rises, out_data/out_x/out_y/out_eol/out_eof hold stable until out_ready.
- Reset (any time, including mid-frame): IDLE, FIFO and in-flight state flushed, all outputs 0. The abandoned frame never completes and done does not pulse.

## Timing
- Reset values: busy, done, err, out_valid, out_eol, out_eof = 0. out_data, out_x, out_y, mem_cell_x, mem_cell_y = 0. mem_we = 0 always.
- Edge E0 samples start. After E0, busy = 1 and the first address is on mem_cell_x/y. The memory samples it at E1. The FIFO captures the data at E2. out_valid is high after E2, a 2-cycle latency.
- With out_ready held at 1, throughput is one pixel per cycle and there are no bubbles after the first beat.
- done is high in the cycle after the edge that accepts the eof beat. busy falls on that same edge.
- A new start is accepted earliest in the cycle done is high. That start is sampled in IDLE.

## Structure
- Shared package vt512_img_pkg holds:
  - the coordinate width localparam
  - the coordinate typedef
  - the FSM state enum
  - the stream beat struct (data, x, y, eol, eof)
- One sub-module, stream_fifo: synchronous, depth 4, with occupancy count output and the same clk/rst_n.

## Test plan
- 4x3 frame, pad_en=0, memory preloaded with value = 16*y + x, out_ready=1:
  - 12 beats back-to-back, first beat (1,1)=0x11, last beat (4,3)=0x34.
  - eol on x=4, eof on the final beat only.
  - done 1 cycle after the final beat is accepted.
- Same frame with pad_en=1: 30 beats. Every beat with x ∈ {0,5} or y ∈ {0,4} reads 0x00. eof falls on (5,4).
- Random out_ready at 30% duty:
  - the beat sequence is identical to the first test
  - outputs are stable while stalled
  - FIFO never overflows (reads are throttled by credits)
- start with W=0, with H=MAX_IMAGE_SIZE+1, and with a start while busy:
  - err pulses once for each of the first two
  - nothing pulses for the third
  - the frame in progress is unaffected.
- 1x1 frame: a single beat with both eol and eof set, then done.
- rst_n asserted mid-frame after 5 beats: all outputs 0 immediately. A subsequent start replays the full frame from (1,1).
